// File: rtl/median_win_seq.sv
// median_win_seq: input sequencer for the median sorting-cell array.
// Accepts one sample per valid/ready handshake, broadcasts it to the array as
// an insert (window filling) or replace-oldest (window full), tracks the
// circular age pointer, and paces issues to the array settle latency.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready upstream handshake; in_data is the sample
//   win_size          requested odd window length, sampled only in IDLE
//   flush             abandon the window and return to IDLE
//   cell_en/cell_op   one-cycle issue strobe and op (01 insert, 10 replace)
//   cell_data         broadcast sample, valid with cell_en
//   age_ptr           tag index of the oldest sample
//   fill_cnt          samples currently in the window
//   med_idx           array position of the median, (N-1)/2
//   med_valid         one-cycle strobe when the array median is valid
//   cfg_err           sticky illegal-window-size flag
//
// ARR_LAT is assumed to be at least 1.
module median_win_seq #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAXN    = 15,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned ARR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  win_size,
    input  logic              flush,
    output logic              cell_en,
    output logic [1:0]        cell_op,
    output logic [DATA_W-1:0] cell_data,
    output logic [CNT_W-1:0]  age_ptr,
    output logic [CNT_W-1:0]  fill_cnt,
    output logic [CNT_W-1:0]  med_idx,
    output logic              med_valid,
    output logic              cfg_err
);

    localparam int unsigned LAT_W = $clog2(ARR_LAT + 1);
    localparam logic [CNT_W-1:0] MAXN_C = CNT_W'(MAXN);

    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_INSERT  = 2'b01;
    localparam logic [1:0] OP_REPLACE = 2'b10;

    typedef enum logic [1:0] {StIdle, StFill, StRun, StWait} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0]    age_q, age_d;
    logic [CNT_W-1:0]    med_idx_q, med_idx_d;
    logic                cfg_err_q, cfg_err_d;
    logic                en_q, en_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                mv_q, mv_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                ret_run_q, ret_run_d;

    logic size_legal;
    logic xfer;

    assign size_legal = (win_size != '0) && win_size[0] && (win_size <= MAXN_C);
    assign in_ready   = (state_q == StFill) || (state_q == StRun);
    assign xfer       = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        fill_d    = fill_q;
        age_d     = age_q;
        med_idx_d = med_idx_q;
        cfg_err_d = cfg_err_q;
        en_d      = 1'b0;
        op_d      = OP_NONE;
        data_d    = data_q;
        mv_d      = 1'b0;
        lat_d     = lat_q;
        ret_run_d = ret_run_q;

        if (flush) begin
            // Flush beats any concurrent transfer; the sample is dropped.
            state_d = StIdle;
            fill_d  = '0;
            age_d   = '0;
            if (size_legal) begin
                cfg_err_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A flagged config waits for a flush; it is not re-tried here.
                    if (!cfg_err_q) begin
                        if (size_legal) begin
                            n_d       = win_size;
                            med_idx_d = (win_size - CNT_W'(1)) >> 1;
                            fill_d    = '0;
                            age_d     = '0;
                            state_d   = StFill;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                StFill: begin
                    if (xfer) begin
                        en_d      = 1'b1;
                        op_d      = OP_INSERT;
                        data_d    = in_data;
                        fill_d    = fill_q + CNT_W'(1);
                        ret_run_d = ((fill_q + CNT_W'(1)) == n_q);
                        lat_d     = LAT_W'(ARR_LAT);
                        state_d   = StWait;
                    end
                end
                StRun: begin
                    if (xfer) begin
                        en_d      = 1'b1;
                        op_d      = OP_REPLACE;
                        data_d    = in_data;
                        ret_run_d = 1'b1;
                        lat_d     = LAT_W'(ARR_LAT);
                        state_d   = StWait;
                    end
                end
                StWait: begin
                    // age_ptr is held through the issue cycle so the array sees
                    // the tag being replaced, then advances.
                    if (en_q && (op_q == OP_REPLACE)) begin
                        age_d = (age_q == (n_q - CNT_W'(1))) ? '0 : age_q + CNT_W'(1);
                    end
                    if (lat_q <= LAT_W'(1)) begin
                        state_d = ret_run_q ? StRun : StFill;
                        mv_d    = (fill_q == n_q);
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            n_q       <= '0;
            fill_q    <= '0;
            age_q     <= '0;
            med_idx_q <= '0;
            cfg_err_q <= 1'b0;
            en_q      <= 1'b0;
            op_q      <= OP_NONE;
            data_q    <= '0;
            mv_q      <= 1'b0;
            lat_q     <= '0;
            ret_run_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            fill_q    <= fill_d;
            age_q     <= age_d;
            med_idx_q <= med_idx_d;
            cfg_err_q <= cfg_err_d;
            en_q      <= en_d;
            op_q      <= op_d;
            data_q    <= data_d;
            mv_q      <= mv_d;
            lat_q     <= lat_d;
            ret_run_q <= ret_run_d;
        end
    end

    assign cell_en   = en_q;
    assign cell_op   = op_q;
    assign cell_data = data_q;
    assign age_ptr   = age_q;
    assign fill_cnt  = fill_q;
    assign med_idx   = med_idx_q;
    assign med_valid = mv_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_median_win_seq.sv
// Directed bench for median_win_seq. Inputs are driven and outputs sampled on
// the falling clock edge. CNT_W=5 so that win_size=17 is representable.
module tb_median_win_seq;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MAXN    = 15;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned ARR_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CNT_W-1:0]  win_size;
    logic              flush;
    logic              cell_en;
    logic [1:0]        cell_op;
    logic [DATA_W-1:0] cell_data;
    logic [CNT_W-1:0]  age_ptr;
    logic [CNT_W-1:0]  fill_cnt;
    logic [CNT_W-1:0]  med_idx;
    logic              med_valid;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;

    median_win_seq #(
        .DATA_W (DATA_W),
        .MAXN   (MAXN),
        .CNT_W  (CNT_W),
        .ARR_LAT(ARR_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .win_size (win_size),
        .flush    (flush),
        .cell_en  (cell_en),
        .cell_op  (cell_op),
        .cell_data(cell_data),
        .age_ptr  (age_ptr),
        .fill_cnt (fill_cnt),
        .med_idx  (med_idx),
        .med_valid(med_valid),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Issue one sample from FILL/RUN and follow it through the settle window.
    task automatic drive_sample(input logic [7:0] d, input logic [1:0] exp_op,
                                input logic [4:0] exp_age, input logic [4:0] exp_fill,
                                input logic exp_mv);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL pre_ready got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        step();
        checks++;
        if (cell_en !== 1'b1) begin
            errors++; $display("FAIL issue_en got %b want 1 (data %0d)", cell_en, d);
        end
        checks++;
        if (cell_op !== exp_op) begin
            errors++; $display("FAIL issue_op got %b want %b (data %0d)", cell_op, exp_op, d);
        end
        checks++;
        if (cell_data !== d) begin
            errors++; $display("FAIL issue_data got %0d want %0d", cell_data, d);
        end
        checks++;
        if (age_ptr !== exp_age) begin
            errors++; $display("FAIL issue_age got %0d want %0d (data %0d)", age_ptr, exp_age, d);
        end
        checks++;
        if (fill_cnt !== exp_fill) begin
            errors++; $display("FAIL issue_fill got %0d want %0d", fill_cnt, exp_fill);
        end
        checks++;
        if (med_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL issue_mv_rdy got %b%b want 00", med_valid, in_ready);
        end
        step();
        checks++;
        if (cell_en !== 1'b0 || cell_op !== 2'b00 || med_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL wait1 got en=%b op=%b mv=%b rdy=%b want 0 00 0 0",
                               cell_en, cell_op, med_valid, in_ready);
        end
        step();
        checks++;
        if (med_valid !== exp_mv) begin
            errors++; $display("FAIL expiry_mv got %b want %b (data %0d)", med_valid, exp_mv, d);
        end
        checks++;
        if (in_ready !== 1'b1 || cell_en !== 1'b0) begin
            errors++; $display("FAIL expiry_rdy got rdy=%b en=%b want 1 0", in_ready, cell_en);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; win_size = 5'd5; flush = 1'b0;
        step(); step();
        checks++;
        if ({in_ready, cell_en, cell_op, med_valid, cfg_err} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000",
                               {in_ready, cell_en, cell_op, med_valid, cfg_err});
        end
        checks++;
        if ({cell_data, age_ptr, fill_cnt, med_idx} !== 23'b0) begin
            errors++; $display("FAIL reset_data got %0h want 0",
                               {cell_data, age_ptr, fill_cnt, med_idx});
        end
    endtask

    task automatic test_fill_run();
        logic [4:0] ages [7];
        ages = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd1};
        rst_n = 1'b1;
        step();
        checks++;
        if (med_idx !== 5'd2) begin
            errors++; $display("FAIL fill_med_idx got %0d want 2", med_idx);
        end
        for (int i = 0; i < 5; i++) begin
            drive_sample(8'(10 * (i + 1)), 2'b01, 5'd0, 5'(i + 1), (i == 4));
        end
        for (int i = 0; i < 7; i++) begin
            drive_sample(8'(60 + 10 * i), 2'b10, ages[i], 5'd5, 1'b1);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1; in_data = 8'hAA;
        step();
        checks++;
        if (cell_en !== 1'b1) begin
            errors++; $display("FAIL rmw_issue got %b want 1", cell_en);
        end
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        checks++;
        if ({in_ready, cell_en, cell_op, med_valid, cfg_err, cell_data, age_ptr, fill_cnt,
             med_idx} !== 29'b0) begin
            errors++; $display("FAIL rmw_zero got en=%b op=%b age=%0d fill=%0d rdy=%b",
                               cell_en, cell_op, age_ptr, fill_cnt, in_ready);
        end
        step();
        checks++;
        if (med_valid !== 1'b0) begin
            errors++; $display("FAIL rmw_no_mv got %b want 0", med_valid);
        end
        rst_n = 1'b1;
        step();
        drive_sample(8'h21, 2'b01, 5'd0, 5'd1, 1'b0);
    endtask

    task automatic test_cfg_err();
        win_size = 5'd4; flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b1; in_data = 8'hEE;
        step();
        checks++;
        if (cfg_err !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL cfg_even got err=%b rdy=%b want 1 0", cfg_err, in_ready);
        end
        win_size = 5'd17;
        step(); step();
        checks++;
        if (cfg_err !== 1'b1 || in_ready !== 1'b0 || cell_en !== 1'b0) begin
            errors++; $display("FAIL cfg_big got err=%b rdy=%b en=%b want 1 0 0",
                               cfg_err, in_ready, cell_en);
        end
        win_size = 5'd3;
        step(); step();
        checks++;
        if (cfg_err !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL cfg_sticky got err=%b rdy=%b want 1 0", cfg_err, in_ready);
        end
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (cfg_err !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL cfg_clear got err=%b rdy=%b want 0 0", cfg_err, in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || med_idx !== 5'd1 || fill_cnt !== 5'd0) begin
            errors++; $display("FAIL cfg_fill got rdy=%b idx=%0d fill=%0d want 1 1 0",
                               in_ready, med_idx, fill_cnt);
        end
        drive_sample(8'd7, 2'b01, 5'd0, 5'd1, 1'b0);
        drive_sample(8'd3, 2'b01, 5'd0, 5'd2, 1'b0);
        drive_sample(8'd5, 2'b01, 5'd0, 5'd3, 1'b1);
        drive_sample(8'd9, 2'b10, 5'd0, 5'd3, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic test_n1();
        win_size = 5'd1; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        checks++;
        if (med_idx !== 5'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL n1_cfg got idx=%0d rdy=%b want 0 1", med_idx, in_ready);
        end
        drive_sample(8'd100, 2'b01, 5'd0, 5'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_sample(8'(101 + i), 2'b10, 5'd0, 5'd1, 1'b1);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush_xfer();
        win_size = 5'd5; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            drive_sample(8'(i + 1), 2'b01, 5'd0, 5'(i + 1), (i == 4));
        end
        drive_sample(8'd40, 2'b10, 5'd0, 5'd5, 1'b1);
        win_size = 5'd7;
        drive_sample(8'd41, 2'b10, 5'd1, 5'd5, 1'b1);
        drive_sample(8'd42, 2'b10, 5'd2, 5'd5, 1'b1);
        checks++;
        if (med_idx !== 5'd2) begin
            errors++; $display("FAIL run_ignore_ws got idx=%0d want 2", med_idx);
        end
        in_valid = 1'b1; in_data = 8'h99; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (cell_en !== 1'b0 || in_ready !== 1'b0 || fill_cnt !== 5'd0 || age_ptr !== 5'd0) begin
            errors++; $display("FAIL flush_drop got en=%b rdy=%b fill=%0d age=%0d want 0 0 0 0",
                               cell_en, in_ready, fill_cnt, age_ptr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cell_en !== 1'b0 || med_valid !== 1'b0) begin
                errors++; $display("FAIL flush_quiet got en=%b mv=%b want 0 0", cell_en, med_valid);
            end
        end
        checks++;
        if (med_idx !== 5'd3 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_new_n got idx=%0d rdy=%b want 3 1", med_idx, in_ready);
        end
        drive_sample(8'h11, 2'b01, 5'd0, 5'd1, 1'b0);
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_run();
        test_reset_mid_wait();
        test_cfg_err();
        test_n1();
        test_flush_xfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
